calc_arbiter: RTL and testbench
===============================

// Module: calc_arbiter
// PURPOSE
//  Shares one small_calc_top instance (4-bit, 2-bit op) between NREQ requesters.
//  Picks one pending request round-robin and registers its op/x/y.
//  Launches the calculator with a go_calc pulse and waits for done.
//  Returns the result to the granted requester with a one-cycle ack; a watchdog flags hung operations.
// PARAMETERS
//  NREQ     2   number of requesters (2..4)
//  TIMEOUT  15  max cycles in WAIT before abort; counter width = $clog2(TIMEOUT+1)
// PORTS
//  clk        in   1         single clock; all state updates on posedge
//  rst        in   1         asynchronous, active-low reset (asserts immediately, release sync'd externally)
//  req        in   NREQ      per-requester request level
//  op_flat    in   2*NREQ    op of requester i at [2i+1:2i]
//  x_flat     in   4*NREQ    x operand of requester i at [4i+3:4i]
//  y_flat     in   4*NREQ    y operand of requester i at [4i+3:4i]
//  ack        out  NREQ      one-hot, one-cycle: result for requester i valid this cycle
//  rsp_data   out  4         result, valid only while |ack
//  err        out  1         qualifies ack: 1 = timeout abort, rsp_data=0
//  busy       out  1         high in every state except IDLE
//  go_calc    out  1         to small_calc_top.go_calc
//  calc_op    out  2         to small_calc_top.op (registered, stable LAUNCH..RESP)
//  calc_x     out  4         to small_calc_top.x (registered)
//  calc_y     out  4         to small_calc_top.y (registered)
//  calc_done  in   1         from small_calc_top.done
//  calc_out   in   4         from small_calc_top.out
// BEHAVIOUR
//  Reset (rst=0): state=IDLE, rr_ptr=0, all outputs 0, operand regs 0, wdog=0.
//  FSM: IDLE -> LAUNCH -> WAIT -> RESP -> DRAIN -> IDLE.
//  - IDLE: if |req, select g = first set bit searching from rr_ptr upward with wrap.
//    Latch op/x/y of g into calc_* regs; store g; go to LAUNCH. Else stay.
//  - LAUNCH: go_calc=1 for exactly this cycle; wdog cleared; go to WAIT.
//  - WAIT: wdog++ each cycle.
//    If calc_done=1: latch calc_out; go to RESP, err_next=0.
//    Else if wdog==TIMEOUT: rsp=0; go to RESP, err_next=1.
//    calc_done takes priority when it coincides with the timeout cycle.
//  - RESP: ack[g]=1, rsp_data and err driven for 1 cycle; rr_ptr <= (g+1) mod NREQ.
//    Go to DRAIN.
//  - DRAIN: wait for calc_done=0, then IDLE.
//    If err was set, go to IDLE without waiting; wdog is not reused here.
//  Latency: req seen in IDLE cycle t -> go_calc at t+1 -> ack at (done cycle)+1.
//    Minimum t+3 when done arrives the cycle after go.
//  Handshake: requester holds req and operands until it sees ack[i].
//    It drops req the following cycle.
//    Operand changes after the grant edge are ignored (values are registered).
//  req[i] still high in IDLE after its ack is treated as a new request.
//    Round-robin still serves other pending requesters first.
//  req deasserted while granted: operation completes; ack is still pulsed.
//  Simultaneous requests: strict round-robin from rr_ptr; no requester starves.
//    Max wait = NREQ-1 full operations.
//  calc_done=1 while in IDLE/LAUNCH: ignored.
//  rst asserted mid-operation: immediate return to IDLE, no ack.
//    Calculator reset is handled by the top level.
//  Widths: no arithmetic besides wdog and rr_ptr; rr_ptr wraps NREQ-1 -> 0.
// STRUCTURE
//  calc_arb_pkg: state encoding (IDLE..DRAIN, 3 bits), OP_W=2, DATA_W=4, op codes.
//  Sub-module rr_picker (combinational): req, rr_ptr -> one-hot gnt and index.
//  FSM, operand regs, watchdog and response regs live in calc_arbiter.
// TESTING
//  1. Single req[0]=1, op=ADD, x=3, y=4, model done 3 cyc after go.
//     -> go_calc one pulse, ack=01, rsp_data=7, err=0.
//  2. req=11 held for 4 ops -> grant order 0,1,0,1; each ack one-hot with correct result.
//  3. Stub calc never asserts done, TIMEOUT=15.
//     -> ack at go+17 cycles, err=1, rsp_data=0, FSM back in IDLE.
//  4. Change x_flat in the cycle after grant -> result uses the original x; calc_x stable until RESP.
//  5. Assert rst low while in WAIT -> all outputs 0 that cycle, no ack.
//     After release, req[1] is served first-available from rr_ptr=0.
//  6. Stub done held high 3 cycles after the result -> no new go_calc until done falls.

Source files
------------

// File: rtl/calc_arb_pkg.sv
// calc_arb_pkg: shared FSM encoding, widths and op codes for calc_arbiter.
package calc_arb_pkg;
  localparam int OP_W = 2;
  localparam int DATA_W = 4;
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP, S_DRAIN} state_e;
  typedef enum logic [OP_W-1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} op_e;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: first pending request at or above ptr_i, wrapping, as one-hot and index.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IW = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            vld_o
);
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    // Walk from the farthest slot back so the closest one to ptr_i wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % NREQ]) begin
        idx_o = IW'((int'(ptr_i) + k) % NREQ);
        vld_o = 1'b1;
      end
    end
    gnt_o = vld_o ? NREQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin sharing of one small_calc_top between NREQ requesters,
// with registered operands, one-cycle ack and a watchdog on the calculator's done.
module calc_arbiter
  import calc_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_i,
  input  logic [OP_W*NREQ-1:0]   op_flat_i,
  input  logic [DATA_W*NREQ-1:0] x_flat_i,
  input  logic [DATA_W*NREQ-1:0] y_flat_i,
  output logic [NREQ-1:0]        ack_o,
  output logic [DATA_W-1:0]      rsp_data_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic                   go_calc_o,
  output logic [OP_W-1:0]        calc_op_o,
  output logic [DATA_W-1:0]      calc_x_o,
  output logic [DATA_W-1:0]      calc_y_o,
  input  logic                   calc_done_i,
  input  logic [DATA_W-1:0]      calc_out_i
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, g_q, g_d, pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic pick_vld;
  logic [OP_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d, rsp_q, rsp_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic err_q, err_d;
  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i(req_i),
    .ptr_i(rr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .vld_o(pick_vld)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      wdog_q  <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wdog_q  <= wdog_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    wdog_d  = wdog_q;
    rsp_d   = rsp_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (pick_vld) begin
        g_d = pick_idx;
        for (int i = 0; i < NREQ; i++) begin
          if (pick_gnt[i]) begin
            op_d = op_flat_i[i*OP_W +: OP_W];
            x_d  = x_flat_i[i*DATA_W +: DATA_W];
            y_d  = y_flat_i[i*DATA_W +: DATA_W];
          end
        end
        state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      // A done arriving on the timeout cycle still wins over the abort.
      S_WAIT: begin
        wdog_d = wdog_q + WW'(1);
        if (calc_done_i) begin
          rsp_d   = calc_out_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wdog_q == WW'(TIMEOUT)) begin
          rsp_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rr_d    = (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);
        state_d = S_DRAIN;
      end
      S_DRAIN: state_d = (err_q || !calc_done_i) ? S_IDLE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    go_calc_o  = state_q == S_LAUNCH;
    busy_o     = state_q != S_IDLE;
    ack_o      = (state_q == S_RESP) ? NREQ'(1) << g_q : '0;
    rsp_data_o = (state_q == S_RESP) ? rsp_q : '0;
    err_o      = (state_q == S_RESP) && err_q;
  end
  assign calc_op_o = op_q;
  assign calc_x_o  = x_q;
  assign calc_y_o  = y_q;
endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: directed and randomized checks of calc_arbiter against a
// round-robin/arithmetic reference model, with a behavioural calculator stub.
module tb_calc_arbiter;
  import calc_arb_pkg::*;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [1:0] op [N];
  logic [3:0] x [N];
  logic [3:0] y [N];
  logic [2*N-1:0] op_flat;
  logic [4*N-1:0] x_flat, y_flat;
  logic [N-1:0] ack;
  logic [3:0] rsp_data, calc_x, calc_y;
  logic [1:0] calc_op;
  logic err, busy, go_calc;
  logic calc_done = 1'b0;
  logic [3:0] calc_out = '0;
  int cyc = 0, go_cnt = 0, go_cyc = 0, fall_cyc = 0, pend = 0, hcnt = 0;
  int lat = 3, hold = 1;
  bit hang = 1'b0;
  int checks = 0, errors = 0;
  int rr_m = 0, exp_g = 0, exp_lat = 0, go0 = 0, prev_g = -1;
  logic [3:0] exp_d;
  bit exp_err;

  assign op_flat = {op[1], op[0]};
  assign x_flat  = {x[1], x[0]};
  assign y_flat  = {y[1], y[0]};

  calc_arbiter #(.NREQ(N), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_i(req),
    .op_flat_i(op_flat),
    .x_flat_i(x_flat),
    .y_flat_i(y_flat),
    .ack_o(ack),
    .rsp_data_o(rsp_data),
    .err_o(err),
    .busy_o(busy),
    .go_calc_o(go_calc),
    .calc_op_o(calc_op),
    .calc_x_o(calc_x),
    .calc_y_o(calc_y),
    .calc_done_i(calc_done),
    .calc_out_i(calc_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] calc(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    return (o == OP_ADD) ? a + b : (o == OP_SUB) ? a - b : (o == OP_AND) ? (a & b) : (a | b);
  endfunction

  // Calculator stub: done rises lat cycles after go and stays high for hold cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend <= 0;
      hcnt <= 0;
      calc_done <= 1'b0;
    end else if (go_calc) begin
      go_cnt <= go_cnt + 1;
      go_cyc <= cyc;
      pend <= hang ? 0 : lat;
    end else if (pend == 1) begin
      pend <= 0;
      calc_done <= 1'b1;
      calc_out <= calc(calc_op, calc_x, calc_y);
      hcnt <= hold;
    end else if (pend > 1) begin
      pend <= pend - 1;
    end else if (hcnt == 1) begin
      hcnt <= 0;
      calc_done <= 1'b0;
      fall_cyc <= cyc;
    end else if (hcnt > 1) begin
      hcnt <= hcnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic txn_start(input bit e, input int l);
    exp_g = -1;
    for (int k = 0; k < N; k++) if (exp_g < 0 && req[(rr_m + k) % N]) exp_g = (rr_m + k) % N;
    if (exp_g < 0) exp_g = 0;
    exp_err = e;
    exp_d = e ? 4'd0 : calc(op[exp_g], x[exp_g], y[exp_g]);
    exp_lat = l;
    go0 = go_cnt;
  endtask

  task automatic txn_finish(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = |ack;
    end
    chk({tag, ".ack_seen"}, 32'(ok), 32'd1);
    chk({tag, ".ack"}, 32'(ack), 32'(1 << exp_g));
    chk({tag, ".rsp"}, 32'(rsp_data), 32'(exp_d));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".lat"}, 32'(cyc - go_cyc), 32'(exp_lat));
    chk({tag, ".go_cnt"}, 32'(go_cnt - go0), 32'd1);
    rr_m = (exp_g + 1) % N;
  endtask

  task automatic wait_go(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = go_calc;
    end
    chk({tag, ".go_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      op[i] = '0;
      x[i] = '0;
      y[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.go", 32'(go_calc), 32'd0);
    chk("rst.calc_regs", 32'({calc_op, calc_x, calc_y}), 32'd0);
    chk("rst.rsp_err", 32'({rsp_data, err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // Two requesters held high: strict alternation starting at requester 0.
    op[0] = OP_ADD; x[0] = 4'd1; y[0] = 4'd2;
    op[1] = OP_SUB; x[1] = 4'd9; y[1] = 4'd4;
    req = 2'b11; lat = 2; hold = 1;
    for (int k = 0; k < 4; k++) begin
      txn_start(1'b0, 3);
      txn_finish($sformatf("t2.%0d", k));
      chk($sformatf("t2.order%0d", k), 32'(exp_g), 32'(k % 2));
    end
    op[0] = OP_ADD; x[0] = 4'd3; y[0] = 4'd4;
    req = 2'b01; lat = 3;
    txn_start(1'b0, 4);
    txn_finish("t1");
    chk("t1.rsp7", 32'(rsp_data), 32'd7);
    hang = 1'b1;
    op[1] = OP_OR; x[1] = 4'd5; y[1] = 4'd10;
    req = 2'b10;
    txn_start(1'b1, 17);
    txn_finish("t3");
    req = '0;
    hang = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3.idle", 32'(busy), 32'd0);
    // Operand change right after the grant must not leak into the operation.
    op[0] = OP_ADD; x[0] = 4'd5; y[0] = 4'd2;
    req = 2'b01; lat = 4;
    txn_start(1'b0, 5);
    wait_go("t4");
    x[0] = 4'd9;
    @(negedge clk);
    chk("t4.calc_x", 32'(calc_x), 32'd5);
    txn_finish("t4");
    chk("t4.calc_x_resp", 32'(calc_x), 32'd5);
    req = '0;
    op[0] = OP_AND; x[0] = 4'd12; y[0] = 4'd10;
    req = 2'b01; lat = 10;
    wait_go("t5");
    repeat (2) @(negedge clk);
    chk("t5.busy_wait", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5.outs_zero", 32'({ack, rsp_data, err, busy, go_calc, calc_op, calc_x, calc_y}), 32'd0);
    repeat (2) @(negedge clk);
    chk("t5.no_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    rr_m = 0;
    op[1] = OP_SUB; x[1] = 4'd3; y[1] = 4'd5;
    req = 2'b10; lat = 2;
    txn_start(1'b0, 3);
    txn_finish("t5");
    // Long done: the next launch must wait for done to fall.
    op[0] = OP_OR; x[0] = 4'd1; y[0] = 4'd2;
    op[1] = OP_ADD; x[1] = 4'd7; y[1] = 4'd8;
    req = 2'b11; lat = 1; hold = 3;
    txn_start(1'b0, 2);
    txn_finish("t6a");
    txn_start(1'b0, 2);
    txn_finish("t6b");
    chk("t6.go_after_fall", 32'(go_cyc - fall_cyc), 32'd2);
    req = '0;
    prev_g = -1;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) begin
        if (i == prev_g || !req[i]) begin
          op[i] = 2'($urandom);
          x[i] = 4'($urandom);
          y[i] = 4'($urandom);
          req[i] = 1'($urandom_range(0, 1));
        end
      end
      if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
      lat = $urandom_range(1, 4);
      hold = $urandom_range(1, 3);
      txn_start(1'b0, lat + 1);
      txn_finish($sformatf("rnd%0d", t));
      prev_g = exp_g;
    end
    req = '0;
    repeat (6) @(negedge clk);
    chk("end.idle", 32'(busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
